// File: rtl/inst_fetch_pkg.sv
// Shared constants, types and helpers for the instruction fetch stage.
// Optional feature macro: FETCH_PERF_CNT_EN (adds saturating perf counters).
package inst_fetch_pkg;

  // Default first fetch address after reset
  localparam logic [31:0] RESET_PC_DEF         = 32'h8000_0000;
  // Canonical NOP (addi x0, x0, 0) shown to decode when nothing is valid
  localparam logic [31:0] INST_NOP             = 32'h0000_0013;
  // Default prefetch depth (also the max number of reads in flight)
  localparam int          FETCH_FIFO_DEPTH_DEF = 4;

  // One prefetch entry: the word and the PC it was fetched from
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    logic [31:0] res;
    if (val == 32'hFFFF_FFFF) begin
      res = val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
// Push and pop in the same cycle leave the count unchanged.
module inst_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_pop_s;
  logic             do_push_s;

  // A flush wins over everything; pop only from a non-empty queue, push
  // only when there is room (a pop in the same cycle frees a slot)
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (flush) begin
      do_pop_s  = 1'b0;
      do_push_s = 1'b0;
    end else begin
      do_pop_s  = pop && (count_r != CNT_ZERO);
      do_push_s = push && ((count_r != CNT_FULL) || do_pop_s);
    end
  end

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word reads to imem,
// buffers returned words with their PCs and presents them to decode.
// A redirect flushes the buffers and marks every read still in flight as
// stale so its response is thrown away when it arrives.
// Optional feature macro: FETCH_PERF_CNT_EN (perf_fetch_o/perf_drop_o/perf_stall_o).
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [31:0] req_addr_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_drop_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW:0]   CREDITS  = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_r;
  logic [CW-1:0] outstanding_nxt_s;
  logic [CW-1:0] drop_nxt_s;
  logic [CW-1:0] data_count_s;
  logic [CW-1:0] tag_count_s;
  logic [CW:0]   credit_used_s;
  logic [31:0]   tag_head_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  head_entry_s;
  logic          req_valid_s;
  logic          accept_s;
  logic          rsp_valid_s;
  logic          rsp_keep_s;
  logic          rsp_drop_s;
  logic          inst_valid_s;
  logic          pop_s;

  // Issue only while every read in flight plus every buffered word still
  // fits in the prefetch FIFO, so a returning response always has a slot
  always_comb begin
    credit_used_s = {1'b0, outstanding_r} + {1'b0, data_count_s};
    req_valid_s   = 1'b0;
    if (rst || jump_en_i) begin
      req_valid_s = 1'b0;
    end else begin
      req_valid_s = (credit_used_s < CREDITS);
    end
    accept_s = req_valid_s && req_ready_i;
  end

  // Classify a response: stale (pending drop or arriving with a redirect)
  // or kept; a response with nothing outstanding is ignored entirely
  always_comb begin
    rsp_valid_s = rsp_valid_i && (outstanding_r != CNT_ZERO);
    rsp_drop_s  = 1'b0;
    rsp_keep_s  = 1'b0;
    if (rsp_valid_s) begin
      rsp_drop_s = jump_en_i || (drop_r != CNT_ZERO);
      rsp_keep_s = !rsp_drop_s && (tag_count_s != CNT_ZERO);
    end else begin
      rsp_drop_s = 1'b0;
      rsp_keep_s = 1'b0;
    end
  end

  // In-flight and stale-read counters; on a redirect everything still in
  // flight after this cycle's response becomes stale, so repeated
  // redirects never count a read twice
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    drop_nxt_s        = drop_r;
    if (accept_s && !rsp_valid_s) begin
      outstanding_nxt_s = outstanding_r + CNT_ONE;
    end else if (!accept_s && rsp_valid_s) begin
      outstanding_nxt_s = outstanding_r - CNT_ONE;
    end else begin
      outstanding_nxt_s = outstanding_r;
    end
    if (jump_en_i) begin
      if (rsp_valid_s) begin
        drop_nxt_s = outstanding_r - CNT_ONE;
      end else begin
        drop_nxt_s = outstanding_r;
      end
    end else if (rsp_valid_s && (drop_r != CNT_ZERO)) begin
      drop_nxt_s = drop_r - CNT_ONE;
    end else begin
      drop_nxt_s = drop_r;
    end
  end

  // PC and read-tracking state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      drop_r        <= CNT_ZERO;
    end else begin
      outstanding_r <= outstanding_nxt_s;
      drop_r        <= drop_nxt_s;
      if (jump_en_i) begin
        pc_r <= jump_addr_i & 32'hFFFF_FFFC;
      end else if (accept_s) begin
        pc_r <= pc_r + 32'd4;
      end
    end
  end

  // Address tags captured at issue, consumed in order by kept responses
  inst_fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (accept_s),
    .push_data (pc_r),
    .pop       (rsp_keep_s),
    .flush     (jump_en_i),
    .head_data (tag_head_s),
    .count     (tag_count_s)
  );

  assign push_entry_s = '{addr: tag_head_s, inst: rsp_data_i};

  // Prefetch buffer holding {addr, inst} pairs for decode
  inst_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_data_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (jump_en_i),
    .head_data (head_entry_s),
    .count     (data_count_s)
  );

  // Decode sees the buffer head; idle slots show a NOP at address 0
  always_comb begin
    inst_valid_s = (data_count_s != CNT_ZERO);
    pop_s        = inst_valid_s && !hold_i;
    if (inst_valid_s) begin
      inst_o      = head_entry_s.inst;
      inst_addr_o = head_entry_s.addr;
    end else begin
      inst_o      = INST_NOP;
      inst_addr_o = 32'h0000_0000;
    end
  end

  assign inst_valid_o = inst_valid_s;
  assign req_valid_o  = req_valid_s;
  assign req_addr_o   = pc_r;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_r;
  logic [31:0] perf_drop_r;
  logic [31:0] perf_stall_r;

  // Saturating event counters: accepted reads, stale responses, decode stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_r <= 32'd0;
      perf_drop_r  <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (accept_s) begin
        perf_fetch_r <= sat_inc32(perf_fetch_r);
      end
      if (rsp_drop_s) begin
        perf_drop_r <= sat_inc32(perf_drop_r);
      end
      if (inst_valid_s && hold_i) begin
        perf_stall_r <= sat_inc32(perf_stall_r);
      end
    end
  end

  assign perf_fetch_o = perf_fetch_r;
  assign perf_drop_o  = perf_drop_r;
  assign perf_stall_o = perf_stall_r;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with a small in-order imem responder
// (one cycle after accept). Optional macro: FETCH_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_drop_o;
  logic [31:0] perf_stall_o;
`endif

  int          n_asserts = 0;
  int          n_fails   = 0;
  int          n_accepts = 0;
  bit          rsp_en    = 1'b0;
  logic [31:0] pend[$];

  always #5 clk = ~clk;

  inst_fetch #(
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h8000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_addr_o   (req_addr_o),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_data_i   (rsp_data_i),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .hold_i       (hold_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_o (perf_fetch_o),
    .perf_drop_o  (perf_drop_o),
    .perf_stall_o (perf_stall_o)
`endif
  );

  // imem contents: upper half is the low address half, lower half 16'hBEEF
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], 16'hBEEF};
  endfunction

  task automatic drive_rsp();
    if (rsp_en && !rst && (pend.size() > 0)) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = imem_word(pend[0]);
    end else begin
      rsp_valid_i = 1'b0;
      rsp_data_i  = 32'h0000_0000;
    end
  endtask

  task automatic set_rsp_en(input bit en);
    rsp_en = en;
    drive_rsp();
  endtask

  // One clock: sample the handshake at negedge, update imem after posedge
  task automatic step();
    logic        acc;
    logic [31:0] a;
    logic [31:0] junk;
    @(negedge clk);
    acc = req_valid_o && req_ready_i;
    a   = req_addr_o;
    @(posedge clk);
    #1;
    if (rst) begin
      pend.delete();
    end else begin
      if (rsp_valid_i) junk = pend.pop_front();
      if (acc) begin
        pend.push_back(a);
        n_accepts++;
      end
    end
    drive_rsp();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_data_i  = 32'h0000_0000;
    jump_en_i   = 1'b0;
    jump_addr_i = 32'h0000_0000;
    hold_i      = 1'b0;

    // Reset state
    step();
    step();
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_inst", inst_o, 32'h0000_0013);
    check("rst_addr", inst_addr_o, 32'h0000_0000);
    check("rst_req_valid", {31'd0, req_valid_o}, 32'd0);
    check("rst_req_addr", req_addr_o, 32'h8000_0000);

    // Request asserted and held while imem not ready
    rst = 1'b0;
    #1;
    check("req_valid_up", {31'd0, req_valid_o}, 32'd1);
    step();
    check("req_hold_valid", {31'd0, req_valid_o}, 32'd1);
    check("req_hold_addr", req_addr_o, 32'h8000_0000);

    // Streaming, one instruction per cycle
    req_ready_i = 1'b1;
    set_rsp_en(1'b1);
    step();
    check("stream_lat", {31'd0, inst_valid_o}, 32'd0);
    step();
    check("stream_v0", {31'd0, inst_valid_o}, 32'd1);
    check("stream_a0", inst_addr_o, 32'h8000_0000);
    check("stream_i0", inst_o, 32'h0000_BEEF);
    step();
    check("stream_a1", inst_addr_o, 32'h8000_0004);
    check("stream_i1", inst_o, 32'h0004_BEEF);
    step();
    check("stream_a2", inst_addr_o, 32'h8000_0008);
    step();
    check("stream_a3", inst_addr_o, 32'h8000_000C);
    check("stream_i3", inst_o, 32'h000C_BEEF);

    // Reset mid-stream
    rst = 1'b1;
    #1;
    check("midrst_async", {31'd0, inst_valid_o}, 32'd0);
    step();
    check("midrst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("midrst_inst", inst_o, 32'h0000_0013);
    check("midrst_addr", inst_addr_o, 32'h0000_0000);
    check("midrst_req_addr", req_addr_o, 32'h8000_0000);
    rst = 1'b0;
    drive_rsp();

    // Backpressure: decode held for 10 cycles
    hold_i    = 1'b1;
    n_accepts = 0;
    repeat (10) step();
    check("bp_accepts", n_accepts, 32'd4);
    check("bp_req_valid", {31'd0, req_valid_o}, 32'd0);
    check("bp_head", inst_addr_o, 32'h8000_0000);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", perf_fetch_o, 32'd4);
    check("perf_stall", perf_stall_o, 32'd8);
`endif
    hold_i = 1'b0;
    step();
    check("bp_a1", inst_addr_o, 32'h8000_0004);
    step();
    check("bp_a2", inst_addr_o, 32'h8000_0008);
    step();
    check("bp_a3", inst_addr_o, 32'h8000_000C);
    step();
    check("bp_a4", inst_addr_o, 32'h8000_0010);
    check("bp_i4", inst_o, 32'h0010_BEEF);

    // Redirect with three reads outstanding
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_rsp_en(1'b0);
    repeat (3) step();
    check("j1_pre_req", {31'd0, req_valid_o}, 32'd1);
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h8000_0102;
    #1;
    check("j1_req_blocked", {31'd0, req_valid_o}, 32'd0);
    step();
    jump_en_i = 1'b0;
    set_rsp_en(1'b1);
    check("j1_new_pc", req_addr_o, 32'h8000_0100);
    step();
    check("j1_drop0", {31'd0, inst_valid_o}, 32'd0);
    step();
    check("j1_drop1", {31'd0, inst_valid_o}, 32'd0);
    step();
    check("j1_drop2", {31'd0, inst_valid_o}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_drop3", perf_drop_o, 32'd3);
`endif
    step();
    check("j1_valid", {31'd0, inst_valid_o}, 32'd1);
    check("j1_addr", inst_addr_o, 32'h8000_0100);
    check("j1_inst", inst_o, 32'h0100_BEEF);

    // Redirect coinciding with a response and a ready imem
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h8000_0200;
    #1;
    check("j2_rsp_present", {31'd0, rsp_valid_i}, 32'd1);
    check("j2_req_blocked", {31'd0, req_valid_o}, 32'd0);
    check("j2_old_head", inst_addr_o, 32'h8000_0100);
    step();
    jump_en_i = 1'b0;
    check("j2_flushed", {31'd0, inst_valid_o}, 32'd0);
    step();
    check("j2_drop0", {31'd0, inst_valid_o}, 32'd0);
    step();
    check("j2_drop1", {31'd0, inst_valid_o}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_drop6", perf_drop_o, 32'd6);
`endif
    step();
    check("j2_valid", {31'd0, inst_valid_o}, 32'd1);
    check("j2_addr", inst_addr_o, 32'h8000_0200);
    check("j2_inst", inst_o, 32'h0200_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
